// File: rtl/snes_csync_region_detect_pkg.sv
// snes_csync_region_detect_pkg: shared class/state encodings, default windows and the frame classifier.
package snes_csync_region_detect_pkg;

    typedef enum logic [1:0] {CLS_NTSC = 2'd0, CLS_PAL = 2'd1, CLS_INV = 2'd2} cls_t;
    typedef enum logic {SEEK = 1'b0, COUNT = 1'b1} state_t;

    localparam int NTSC_MIN_DEF = 250;
    localparam int NTSC_MAX_DEF = 275;
    localparam int PAL_MIN_DEF  = 300;
    localparam int PAL_MAX_DEF  = 330;

    function automatic cls_t classify(input logic [9:0] n, nmin, nmax, pmin, pmax);
        return (n >= pmin && n <= pmax) ? CLS_PAL : (n >= nmin && n <= nmax) ? CLS_NTSC : CLS_INV;
    endfunction

endpackage

// File: rtl/snes_csync_pulse_meas.sv
// snes_csync_pulse_meas: synchronises CSYNC, measures pulse width/spacing and raises line, vsync and idle-timeout strobes.
module snes_csync_pulse_meas #(
    parameter int VS_MIN_CLKS   = 300,
    parameter int LINE_MIN_CLKS = 800,
    parameter int TIMEOUT_CLKS  = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic csync,
    output logic line_stb,
    output logic vert_stb,
    output logic hsync_stb,
    output logic timeout_stb
);
    localparam logic [9:0]  VS_MIN = 10'(VS_MIN_CLKS);
    localparam logic [10:0] LN_MIN = 11'(LINE_MIN_CLKS);
    localparam logic [15:0] TO     = 16'(TIMEOUT_CLKS);
    localparam logic [15:0] TO_M1  = 16'(TIMEOUT_CLKS - 1);

    logic [1:0]  sync;
    logic        prev;
    logic [9:0]  width;
    logic [10:0] spacing;
    logic [15:0] idle;
    logic        fall, rise;

    always_comb begin
        fall        = prev & ~sync[1];
        rise        = ~prev & sync[1];
        line_stb    = fall && spacing >= LN_MIN;
        vert_stb    = rise && width >= VS_MIN;
        hsync_stb   = rise && width < VS_MIN;
        timeout_stb = idle == TO_M1 && !fall;
    end

    // Rejected (half-line) edges still count as activity for the idle timer but do not restart spacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            prev    <= 1'b0;
            width   <= '0;
            spacing <= '0;
            idle    <= '0;
        end else begin
            sync    <= {sync[0], csync};
            prev    <= sync[1];
            width   <= fall ? '0 : (!sync[1] && width != '1) ? width + 10'd1 : width;
            spacing <= line_stb ? '0 : spacing != '1 ? spacing + 11'd1 : spacing;
            idle    <= fall ? '0 : idle != TO ? idle + 16'd1 : idle;
        end
    end

endmodule

// File: rtl/snes_csync_region_detect.sv
// snes_csync_region_detect: counts lines per frame from CSYNC and reports a debounced PAL/NTSC lock.
// Optional INTERLACE_DET_EN adds detection of alternating odd/even frame line counts.
module snes_csync_region_detect
    import snes_csync_region_detect_pkg::*;
#(
    parameter int VS_MIN_CLKS   = 300,
    parameter int LINE_MIN_CLKS = 800,
    parameter int NTSC_MIN      = NTSC_MIN_DEF,
    parameter int NTSC_MAX      = NTSC_MAX_DEF,
    parameter int PAL_MIN       = PAL_MIN_DEF,
    parameter int PAL_MAX       = PAL_MAX_DEF,
    parameter int LOCK_FRAMES   = 4,
    parameter int TIMEOUT_CLKS  = 65535
) (
    input  logic       MCLK_i,
    input  logic       NRST_i,
    input  logic       CSYNC_i,
    output logic       PAL_DET_o,
    output logic       LOCKED_o,
    output logic [9:0] LINES_o,
    output logic       FRAME_STB_o,
    output logic       INTERLACED_o
);
    localparam logic [2:0] LOCK = 3'(LOCK_FRAMES);

    logic       line_stb, vert_stb, hsync_stb, timeout_stb;
    state_t     state, state_n;
    logic       prev_vert, first_vert, frame_end;
    logic [9:0] lcnt;
    logic [2:0] dcnt, dcnt_n;
    cls_t       cls, cls_q;

    snes_csync_pulse_meas #(
        .VS_MIN_CLKS  (VS_MIN_CLKS),
        .LINE_MIN_CLKS(LINE_MIN_CLKS),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_meas (
        .clk        (MCLK_i),
        .rst_n      (NRST_i),
        .csync      (CSYNC_i),
        .line_stb   (line_stb),
        .vert_stb   (vert_stb),
        .hsync_stb  (hsync_stb),
        .timeout_stb(timeout_stb)
    );

    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i)
            state <= SEEK;
        else
            state <= state_n;
    end

    // Only the first broad pulse of a vsync group marks a frame boundary; an edge beats a timeout.
    always_comb begin
        first_vert = vert_stb && !prev_vert;
        state_n    = first_vert ? COUNT : timeout_stb ? SEEK : state;
        frame_end  = first_vert && state == COUNT;
        cls        = classify(lcnt, 10'(NTSC_MIN), 10'(NTSC_MAX), 10'(PAL_MIN), 10'(PAL_MAX));
        dcnt_n     = (cls == cls_q && dcnt != '0) ? (dcnt < LOCK ? dcnt + 3'd1 : dcnt) : 3'd1;
    end

    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            prev_vert   <= 1'b0;
            lcnt        <= '0;
            dcnt        <= '0;
            cls_q       <= CLS_NTSC;
            LINES_o     <= '0;
            FRAME_STB_o <= 1'b0;
            LOCKED_o    <= 1'b0;
            PAL_DET_o   <= 1'b0;
        end else begin
            FRAME_STB_o <= frame_end;
            prev_vert   <= vert_stb ? 1'b1 : hsync_stb ? 1'b0 : prev_vert;
            lcnt        <= first_vert ? '0 : (line_stb && lcnt != '1) ? lcnt + 10'd1 : lcnt;
            if (frame_end) begin
                LINES_o <= lcnt;
                if (cls == CLS_INV) begin
                    dcnt     <= '0;
                    LOCKED_o <= 1'b0;
                end else begin
                    dcnt  <= dcnt_n;
                    cls_q <= cls;
                    if (dcnt_n == LOCK) begin
                        LOCKED_o  <= 1'b1;
                        PAL_DET_o <= cls == CLS_PAL;
                    end
                end
            end else if (timeout_stb) begin
                dcnt     <= '0;
                LOCKED_o <= 1'b0;
            end
        end
    end

`ifdef INTERLACE_DET_EN
    logic lsb_q, have_lsb, ilace;

    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            lsb_q    <= 1'b0;
            have_lsb <= 1'b0;
            ilace    <= 1'b0;
        end else if (frame_end && cls != CLS_INV) begin
            ilace    <= have_lsb && (lcnt[0] != lsb_q);
            lsb_q    <= lcnt[0];
            have_lsb <= 1'b1;
        end else if (frame_end || timeout_stb) begin
            have_lsb <= 1'b0;
            ilace    <= 1'b0;
        end
    end

    assign INTERLACED_o = LOCKED_o & ilace;
`else
    assign INTERLACED_o = 1'b0;
`endif

endmodule
